// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the multiplexed seven-segment display path.
package seg_disp_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_MAX   = 4'd9;

  function automatic logic bcd_valid(input logic [3:0] v);
    return v <= BCD_MAX;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Loadable down-counter that paces the BLANK and SHOW phases of the digit scan.
module seg_scan_timer #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loaded with N-1, so the phase lasts exactly N cycles including the done cycle.
  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/seven_seg_scan_controller.sv
// Scans NUM_DIGITS snapshotted BCD digits onto a shared encoder with blanking gaps.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_seg_scan_controller
  import seg_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n,
  output logic                    frame_tick
);

  localparam int unsigned MaxCnt = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);

  localparam logic [CntW-1:0] ShowLoad  = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] BlankLoad = CntW'(BLANK_CYCLES - 1);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_DIGITS - 1);

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LzEn = 1'b1;
`else
  localparam bit LzEn = 1'b0;
`endif

  // Per-digit lit mask: invalid codes are dark; optionally leading zeros too.
  function automatic logic [NUM_DIGITS-1:0] show_mask(input logic [4*NUM_DIGITS-1:0] d,
                                                      input logic [NUM_DIGITS-1:0]   dp);
    logic [NUM_DIGITS-1:0] mask;
    logic                  lead;
    logic [3:0]            v;
    mask = '0;
    lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v       = d[4*i +: 4];
      mask[i] = bcd_valid(v);
      if (LzEn && (i != 0) && lead && (v == 4'd0) && !dp[i]) begin
        mask[i] = 1'b0;
      end
      lead = lead && (v == 4'd0);
    end
    return mask;
  endfunction

  scan_state_t             state_q;
  logic [IdxW-1:0]         idx_q;
  logic [4*NUM_DIGITS-1:0] snap_bcd_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q;
  logic [3:0]              bcd_q;
  logic [NUM_DIGITS-1:0]   an_n_q;
  logic                    dp_n_q;
  logic                    frame_tick_q;

  logic                    tmr_done;
  logic                    tmr_load;
  logic [CntW-1:0]         tmr_val;
  logic [NUM_DIGITS-1:0]   vis_snap;
  logic                    last_idx;
  logic [IdxW-1:0]         idx_nxt;
  logic [3:0]              wrap_bcd;
  logic [3:0]              next_bcd;
  logic [NUM_DIGITS-1:0]   an_show;
  logic                    dp_show;

  always_comb begin
    vis_snap = show_mask(snap_bcd_q, snap_dp_q);
    tmr_load = en && ((state_q == IDLE) || tmr_done);
    tmr_val  = (state_q == BLANK) ? ShowLoad : BlankLoad;
    last_idx = (idx_q == LastIdx);
    idx_nxt  = last_idx ? '0 : idx_q + 1'b1;
    // Digit 0 is never leading-zero blanked, so validity alone decides it.
    wrap_bcd = bcd_valid(digits_bcd[3:0]) ? digits_bcd[3:0] : BCD_BLANK;
    next_bcd = vis_snap[idx_nxt] ? snap_bcd_q[4*idx_nxt +: 4] : BCD_BLANK;
    an_show  = '1;
    if (vis_snap[idx_q]) begin
      an_show[idx_q] = 1'b0;
    end
    dp_show = ~(vis_snap[idx_q] & snap_dp_q[idx_q]);
  end

  seg_scan_timer #(
    .Width(CntW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (~en),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .done_o    (tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      snap_bcd_q   <= '0;
      snap_dp_q    <= '0;
      bcd_q        <= 4'h0;
      an_n_q       <= '1;
      dp_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else if (!en) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      bcd_q        <= 4'h0;
      an_n_q       <= '1;
      dp_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          state_q      <= BLANK;
          idx_q        <= '0;
          snap_bcd_q   <= digits_bcd;
          snap_dp_q    <= dp_in;
          frame_tick_q <= 1'b1;
          bcd_q        <= wrap_bcd;
          an_n_q       <= '1;
          dp_n_q       <= 1'b1;
        end
        BLANK: begin
          if (tmr_done) begin
            state_q <= SHOW;
            an_n_q  <= an_show;
            dp_n_q  <= dp_show;
          end
        end
        SHOW: begin
          if (tmr_done) begin
            state_q <= BLANK;
            idx_q   <= idx_nxt;
            an_n_q  <= '1;
            dp_n_q  <= 1'b1;
            if (last_idx) begin
              snap_bcd_q   <= digits_bcd;
              snap_dp_q    <= dp_in;
              frame_tick_q <= 1'b1;
              bcd_q        <= wrap_bcd;
            end else begin
              bcd_q <= next_bcd;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd_out    = bcd_q;
  assign an_n       = an_n_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Scoreboard bench: a time-position model predicts every output cycle of the scan.
module tb_seven_seg_scan_controller;

  localparam int unsigned N     = 4;
  localparam int unsigned SHOWC = 8;
  localparam int unsigned BLNK  = 2;
  localparam int unsigned SLOT  = SHOWC + BLNK;
  localparam int unsigned FRAME = N * SLOT;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LzEn = 1'b1;
`else
  localparam bit LzEn = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          en;
  logic [15:0]   digits_bcd;
  logic [3:0]    dp_in;
  logic [3:0]    bcd_out;
  logic [3:0]    an_n;
  logic          dp_n;
  logic          frame_tick;

  seven_seg_scan_controller #(
    .NUM_DIGITS  (N),
    .SCAN_DIV    (SHOWC),
    .BLANK_CYCLES(BLNK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .digits_bcd(digits_bcd),
    .dp_in     (dp_in),
    .bcd_out   (bcd_out),
    .an_n      (an_n),
    .dp_n      (dp_n),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic       dp;
    logic       ft;
    logic [3:0] bcd;
    bit         chk_bcd;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;

  // Reference model state: time position within the running scan.
  bit         running = 0;
  int         t = 0;
  logic [15:0] snap = '0;
  logic [3:0]  sdp = '0;

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit visible(input logic [15:0] d, input logic [3:0] dp, input int k);
    logic [3:0] nib;
    bit         upper_zero;
    nib = d[4*k +: 4];
    if (nib > 4'd9) return 1'b0;
    upper_zero = 1'b1;
    for (int j = k; j < int'(N); j++) begin
      if (d[4*j +: 4] != 4'd0) upper_zero = 1'b0;
    end
    if (LzEn && k != 0 && !dp[k] && upper_zero) return 1'b0;
    return 1'b1;
  endfunction

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_step(input logic en_s, input logic [15:0] d_s, input logic [3:0] dp_s);
    exp_t       e;
    int         dig;
    bit         blank;
    bit         lit;
    logic [3:0] one;
    if (!en_s) begin
      running = 0;
    end else if (!running) begin
      running = 1;
      t = 0;
      snap = d_s;
      sdp = dp_s;
    end else begin
      t++;
      if (t % FRAME == 0) begin
        snap = d_s;
        sdp = dp_s;
      end
    end
    if (!running) begin
      e = '{an: 4'hF, dp: 1'b1, ft: 1'b0, bcd: 4'h0, chk_bcd: 1'b0};
    end else begin
      dig   = (t % FRAME) / SLOT;
      blank = (t % SLOT) < BLNK;
      lit   = visible(snap, sdp, dig);
      one   = 4'b0001 << dig;
      e.an  = (!blank && lit) ? ~one : 4'hF;
      e.dp  = (!blank && lit) ? ~sdp[dig] : 1'b1;
      e.ft  = (t % FRAME == 0);
      e.bcd = lit ? snap[4*dig +: 4] : 4'hF;
      e.chk_bcd = 1'b1;
    end
    q.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step(en, digits_bcd, dp_in);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check4("an_n", an_n, e.an);
        check4("dp_n", {3'b0, dp_n}, {3'b0, e.dp});
        check4("frame_tick", {3'b0, frame_tick}, {3'b0, e.ft});
        if (e.chk_bcd) check4("bcd_out", bcd_out, e.bcd);
      end
    end
  end

  initial begin : driver
    rst = 1'b1;
    en = 1'b0;
    digits_bcd = 16'h1234;
    dp_in = 4'b0000;
    #23;
    check4("reset an_n", an_n, 4'hF);
    check4("reset dp_n", {3'b0, dp_n}, 4'h1);
    check4("reset frame_tick", {3'b0, frame_tick}, 4'h0);
    check4("reset bcd_out", bcd_out, 4'h0);
    rst = 1'b0;
    run(3);

    // Order/timing, then a mid-frame digit change while digit 1 is lit.
    en = 1'b1;
    run(15);
    digits_bcd = 16'h5678;
    run(FRAME + 25);

    // Invalid digit in slot 1.
    digits_bcd = 16'h12A4;
    run(FRAME + 5);

    // Decimal point on digit 2.
    digits_bcd = 16'h1234;
    dp_in = 4'b0100;
    run(2 * FRAME);

    // Leading zeros (blanked only when the macro is defined).
    dp_in = 4'b0000;
    digits_bcd = 16'h0050;
    run(2 * FRAME);

    // Drop enable during digit 2 SHOW, then re-enable.
    while (!(running && (t % FRAME) == 2 * SLOT + 4)) cycle();
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(FRAME + 7);

    // Asynchronous reset mid-frame, checked with no clock edge in between.
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check4("async rst an_n", an_n, 4'hF);
    check4("async rst dp_n", {3'b0, dp_n}, 4'h1);
    check4("async rst frame_tick", {3'b0, frame_tick}, 4'h0);
    check4("async rst bcd_out", bcd_out, 4'h0);
    #1;
    rst = 1'b0;
    running = 0;
    run(FRAME + 3);

    // Randomized phase.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) digits_bcd = 16'($urandom);
      if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
      if (en && $urandom_range(0, 299) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      cycle();
    end

    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
